// File: rtl/fir_seq_pkg.sv
// Shared types and constants for the folded 4-tap FIR sequencer.
package fir_seq_pkg;

  localparam int unsigned DW    = 16;
  localparam int unsigned CW    = 8;
  localparam int unsigned NTAPS = 4;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DONE
  } fsm_e;

  typedef logic [1:0] tap_idx_t;

  typedef logic [NTAPS-1:0][CW-1:0] coef_bank_t;

  // Element 0 is x0 (newest sample), element 3 is z3 (oldest).
  typedef logic [NTAPS-1:0][DW-1:0] dly_line_t;

endpackage

// File: rtl/fir_mac_unit.sv
// Shared multiply-accumulate: unsigned DW x CW product, DW-bit wrapping accumulator.
module fir_mac_unit #(
  parameter int unsigned DW = 16,
  parameter int unsigned CW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          en_i,
  input  logic [DW-1:0] sample_i,
  input  logic [CW-1:0] coef_i,
  output logic [DW-1:0] acc_o
);

  logic [DW-1:0] prod_lo;
  logic [DW-1:0] acc_d, acc_q;

  // A DW-wide multiply yields exactly the low DW bits of the full product.
  assign prod_lo = sample_i * {{(DW-CW){1'b0}}, coef_i};

  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + prod_lo;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/fir_seq_ctrl.sv
// Folded 4-tap FIR: one MAC time-shared over the taps, valid/ready in and out,
// double-buffered coefficients that only switch at a sample-accept edge.
module fir_seq_ctrl
  import fir_seq_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  input  logic            coef_we,
  input  tap_idx_t        coef_addr,
  input  logic [CW-1:0]   coef_wdata,
  input  logic            coef_commit,
  input  logic            flush,
  output logic            busy
);

  fsm_e       state_q, state_d;
  tap_idx_t   tap_q, tap_d;
  dly_line_t  dly_q, dly_d;
  coef_bank_t shadow_q, shadow_d;
  coef_bank_t active_q, active_d;
  logic       pending_q, pending_d;

  logic          rdy;
  logic          accept;
  logic          mac_clear;
  logic          mac_en;
  logic [DW-1:0] acc;

  always_comb begin
    state_d   = state_q;
    tap_d     = tap_q;
    rdy       = 1'b0;
    out_valid = 1'b0;
    mac_clear = 1'b0;
    mac_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        rdy = !flush;
      end
      MAC: begin
        mac_en = 1'b1;
        tap_d  = tap_q + 2'd1;
        if (tap_q == 2'd3) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        rdy       = out_ready;
        if (out_ready && !in_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // While reset is held the FSM already sits in IDLE; keep the handshake closed.
    accept = in_valid && rdy && reset_n;
    if (accept) begin
      state_d   = MAC;
      tap_d     = '0;
      mac_clear = 1'b1;
    end
  end

  always_comb begin
    dly_d = dly_q;
    if (accept) begin
      dly_d = {dly_q[NTAPS-2:0], in_data};
    end else if (state_q == IDLE && flush) begin
      dly_d = '0;
    end
  end

  // Same-cycle write and commit both land in the bank that becomes active.
  always_comb begin
    shadow_d = shadow_q;
    if (coef_we) begin
      shadow_d[coef_addr] = coef_wdata;
    end
    pending_d = pending_q || coef_commit;
    active_d  = active_q;
    if (accept && pending_d) begin
      active_d  = shadow_d;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      tap_q     <= '0;
      dly_q     <= '0;
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tap_q     <= tap_d;
      dly_q     <= dly_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

  fir_mac_unit #(
    .DW (DW),
    .CW (CW)
  ) u_mac (
    .clk_i    (clk),
    .rst_ni   (reset_n),
    .clear_i  (mac_clear),
    .en_i     (mac_en),
    .sample_i (dly_q[tap_q]),
    .coef_i   (active_q[tap_q]),
    .acc_o    (acc)
  );

  assign in_ready = rdy && reset_n;
  assign out_data = (state_q == DONE) ? acc : '0;
  assign busy     = (state_q == MAC) || (state_q == DONE);

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Scoreboard bench for fir_seq_ctrl: driver queues expected results and accept
// cycles, a negedge monitor checks latency and data on each output.
module tb_fir_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        coef_we = 1'b0;
  logic [1:0]  coef_addr = '0;
  logic [7:0]  coef_wdata = '0;
  logic        coef_commit = 1'b0;
  logic        flush = 1'b0;
  logic        busy;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [15:0] exp_q[$];
  int          lat_q[$];
  logic        ov_prev = 1'b0;

  fir_seq_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .coef_we     (coef_we),
    .coef_addr   (coef_addr),
    .coef_wdata  (coef_wdata),
    .coef_commit (coef_commit),
    .flush       (flush),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: latency on each rising out_valid, data on each output handshake.
  always @(negedge clk) begin
    if (out_valid && !ov_prev) begin
      if (lat_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out_valid: got out_valid=1 want no pending sample");
      end else begin
        check("latency", cyc - lat_q.pop_front(), 5);
      end
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got %0h want nothing", out_data);
      end else begin
        check("out_data", out_data, exp_q.pop_front());
      end
    end
    ov_prev <= out_valid;
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic send(input logic [15:0] d, input logic [15:0] exp, output int waited);
    in_valid = 1'b1;
    in_data  = d;
    waited   = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!in_ready && waited < 100);
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 want 1 for sample %0h", d);
    end else begin
      exp_q.push_back(exp);
      lat_q.push_back(cyc);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wcoef(input logic [1:0] a, input logic [7:0] v, input logic commit);
    coef_we     = 1'b1;
    coef_addr   = a;
    coef_wdata  = v;
    coef_commit = commit;
    @(posedge clk);
    #1 coef_we  = 1'b0;
    coef_commit = 1'b0;
  endtask

  task automatic set_coefs(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
    wcoef(2'd0, b0, 1'b0);
    wcoef(2'd1, b1, 1'b0);
    wcoef(2'd2, b2, 1'b0);
    wcoef(2'd3, b3, 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int n;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    reset_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_busy", busy, 0);
    @(posedge clk);
    #1;

    // Basic convolution, back-to-back stream.
    set_coefs(8'd1, 8'd2, 8'd3, 8'd4);
    send(16'd10, 16'd10, w);
    send(16'd20, 16'd40, w);
    send(16'd30, 16'd100, w);
    send(16'd40, 16'd200, w);
    drain();

    // Accumulator wrap-around.
    set_coefs(8'hFF, 8'h00, 8'h00, 8'h00);
    send(16'hFFFF, 16'hFF01, w);
    drain();

    // Back-pressure: hold DONE, then release with the next sample waiting.
    out_ready = 1'b0;
    send(16'd1, 16'h00FF, w);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid_seen", out_valid, 1);
    in_valid = 1'b1;
    in_data  = 16'd2;
    repeat (10) begin
      @(negedge clk);
      check("bp_hold_data", out_data, 16'h00FF);
      check("bp_hold_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(16'd2, 16'h01FE, w);
    check("bp_same_cycle_accept", w, 1);
    drain();

    // Commit during MAC only takes effect at the next accept.
    send(16'd10, 16'h09F6, w);
    wcoef(2'd0, 8'd5, 1'b1);
    drain();
    send(16'd3, 16'd15, w);
    drain();

    // Async reset at tap 2 aborts the sample and clears all state.
    send(16'd9, 16'h0000, w);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_busy", busy, 0);
    exp_q.delete();
    lat_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("midrst_release_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    send(16'd7, 16'd0, w);
    drain();

    // Delay line now holds 7; coefficients all ones.
    set_coefs(8'd1, 8'd1, 8'd1, 8'd1);
    send(16'd10, 16'd17, w);
    send(16'd20, 16'd37, w);
    send(16'd30, 16'd67, w);
    drain();

    // Flush beats a same-cycle accept.
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'd99;
    @(negedge clk);
    check("flush_in_ready", in_ready, 0);
    @(posedge clk);
    #1 flush = 1'b0;
    in_valid = 1'b0;
    send(16'd5, 16'd5, w);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
